// File: rtl/sketch_pkg.sv
// Shared types for the sketch bucket stage: entry layout, decide outcomes, clear FSM states.
// entry_t shows the default-width entry layout; the top builds the same shape at its own KEY_W/CNT_W.
package sketch_pkg;

    localparam int KEY_W_DEF = 32;
    localparam int CNT_W_DEF = 32;

    typedef struct packed {
        logic [KEY_W_DEF-1:0] key;
        logic [CNT_W_DEF-1:0] cnt;
    } entry_t;

    typedef enum logic [1:0] {
        INSERT = 2'd0,
        MERGE  = 2'd1,
        SWAP   = 2'd2,
        PASS   = 2'd3
    } outcome_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } clr_state_e;

endpackage

// File: rtl/sketch_bucket_stage_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
// A read and a write to the same address on the same edge return the old contents.
module sdp_ram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sketch_bucket_stage.sv
// One bucket stage of a heavy-hitter sketch: insert, merge, swap or pass each element, with a table clear.
// Define SKETCH_BUCKET_STATS_EN to add saturating per-outcome statistics counters.
module sketch_bucket_stage
    import sketch_pkg::*;
#(
    parameter int IDX_W     = 10,
    parameter int HASH_W    = 32,
    parameter int HASH_BASE = 0,
    parameter int KEY_W     = 32,
    parameter int CNT_W     = 32
`ifdef SKETCH_BUCKET_STATS_EN
    , parameter int STAT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HASH_W-1:0] in_hash,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic              out_valid,
    output logic [KEY_W-1:0]  out_key,
    output logic [CNT_W-1:0]  out_cnt,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
`ifdef SKETCH_BUCKET_STATS_EN
    , output logic [STAT_W-1:0] stat_insert
    , output logic [STAT_W-1:0] stat_merge
    , output logic [STAT_W-1:0] stat_swap
    , output logic [STAT_W-1:0] stat_pass
`endif
);

    localparam int ENT_W = KEY_W + CNT_W;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [CNT_W-1:0] cnt;
    } ent_t;

    clr_state_e       state_q;
    logic             in_ready_q, clear_busy_q, clear_done_q;
    logic [IDX_W-1:0] clr_addr_q;

    logic             s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    ent_t             s1_ent_q, s1_ent_d, s1_hit_ent_q, s1_hit_ent_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    ent_t             s2_ent_q, s2_ent_d, s2_stored_q, s2_stored_d;
    logic             s3_wen_q, s3_wen_d, s3_out_q, s3_out_d;
    logic [IDX_W-1:0] s3_idx_q, s3_idx_d;
    ent_t             s3_wdata_q, s3_wdata_d, s3_out_ent_q, s3_out_ent_d;
    logic             out_valid_q, out_valid_d;
    ent_t             out_ent_q, out_ent_d;

    logic             accept, pipe_empty, clr_last;
    logic [IDX_W-1:0] in_idx;
    logic [ENT_W-1:0] ram_rdata;
    ent_t             stored;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] merged_cnt;
    outcome_e         outcome;
    logic             unused_hash;

    assign accept      = in_valid && in_ready_q;
    assign in_idx      = in_hash[HASH_BASE +: IDX_W];
    assign unused_hash = ^in_hash;
    assign pipe_empty  = !s1_valid_q && !s2_valid_q && !s3_wen_q && !s3_out_q;
    assign clr_last    = (state_q == CLEAR) && (&clr_addr_q);

    sdp_ram #(.ADDR_W(IDX_W), .WIDTH(ENT_W)) u_ram (
        .clk   (clk),
        .we    ((state_q == CLEAR) || s3_wen_q),
        .waddr ((state_q == CLEAR) ? clr_addr_q : s3_idx_q),
        .wdata ((state_q == CLEAR) ? '0 : ENT_W'(s3_wdata_q)),
        .re    (accept),
        .raddr (in_idx),
        .rdata (ram_rdata)
    );

    // Writes issued on the read edge or still queued in s3 bypass the RAM so every decide sees the newest entry.
    always_comb begin
        s1_valid_d   = accept && (in_cnt != '0);
        s1_idx_d     = in_idx;
        s1_ent_d     = ent_t'{key: in_key, cnt: in_cnt};
        s1_hit_d     = s3_wen_q && (s3_idx_q == in_idx);
        s1_hit_ent_d = s3_wdata_q;

        s2_valid_d = s1_valid_q;
        s2_idx_d   = s1_idx_q;
        s2_ent_d   = s1_ent_q;
        if (s3_wen_q && (s3_idx_q == s1_idx_q))
            s2_stored_d = s3_wdata_q;
        else if (s1_hit_q)
            s2_stored_d = s1_hit_ent_q;
        else
            s2_stored_d = ent_t'(ram_rdata);

        stored     = (s3_wen_q && (s3_idx_q == s2_idx_q)) ? s3_wdata_q : s2_stored_q;
        sum        = {1'b0, stored.cnt} + {1'b0, s2_ent_q.cnt};
        merged_cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        if (stored == '0)
            outcome = INSERT;
        else if (stored.key == s2_ent_q.key)
            outcome = MERGE;
        else if (s2_ent_q.cnt > stored.cnt)
            outcome = SWAP;
        else
            outcome = PASS;

        s3_wen_d     = s2_valid_q && (outcome != PASS);
        s3_idx_d     = s2_idx_q;
        s3_wdata_d   = (outcome == MERGE) ? ent_t'{key: stored.key, cnt: merged_cnt} : s2_ent_q;
        s3_out_d     = s2_valid_q && ((outcome == SWAP) || (outcome == PASS));
        s3_out_ent_d = (outcome == SWAP) ? stored : s2_ent_q;

        out_valid_d = s3_out_q;
        out_ent_d   = s3_out_q ? s3_out_ent_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_ent_q     <= '0;
            s1_hit_q     <= 1'b0;
            s1_hit_ent_q <= '0;
            s2_valid_q   <= 1'b0;
            s2_idx_q     <= '0;
            s2_ent_q     <= '0;
            s2_stored_q  <= '0;
            s3_wen_q     <= 1'b0;
            s3_out_q     <= 1'b0;
            s3_idx_q     <= '0;
            s3_wdata_q   <= '0;
            s3_out_ent_q <= '0;
            out_valid_q  <= 1'b0;
            out_ent_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            s1_ent_q     <= s1_ent_d;
            s1_hit_q     <= s1_hit_d;
            s1_hit_ent_q <= s1_hit_ent_d;
            s2_valid_q   <= s2_valid_d;
            s2_idx_q     <= s2_idx_d;
            s2_ent_q     <= s2_ent_d;
            s2_stored_q  <= s2_stored_d;
            s3_wen_q     <= s3_wen_d;
            s3_out_q     <= s3_out_d;
            s3_idx_q     <= s3_idx_d;
            s3_wdata_q   <= s3_wdata_d;
            s3_out_ent_q <= s3_out_ent_d;
            out_valid_q  <= out_valid_d;
            out_ent_q    <= out_ent_d;
        end
    end

    // Clear sequencer: stop input, wait for in-flight writes to land, then zero every address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q      <= DRAIN;
                        in_ready_q   <= 1'b0;
                        clear_busy_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_last) begin
                        state_q      <= IDLE;
                        in_ready_q   <= 1'b1;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign out_valid  = out_valid_q;
    assign out_key    = out_ent_q.key;
    assign out_cnt    = out_ent_q.cnt;

`ifdef SKETCH_BUCKET_STATS_EN
    logic [STAT_W-1:0] stat_q [4];
    logic [STAT_W-1:0] stat_d [4];

    // Counters are indexed by outcome encoding and zeroed on the edge that finishes a clear.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_d[i] = stat_q[i];
            if (clr_last)
                stat_d[i] = '0;
            else if (s2_valid_q && (int'(outcome) == i) && (stat_q[i] != '1))
                stat_d[i] = stat_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) stat_q[i] <= stat_d[i];
        end
    end

    assign stat_insert = stat_q[0];
    assign stat_merge  = stat_q[1];
    assign stat_swap   = stat_q[2];
    assign stat_pass   = stat_q[3];
`endif

endmodule

// File: tb/tb_sketch_bucket_stage.sv
// Scoreboard bench for sketch_bucket_stage: directed elements push expected outputs, a monitor pops and checks them.
// Runs with a small table (16 entries) and 8-bit counts so saturation and full clear sweeps are quick.
module tb_sketch_bucket_stage;

    localparam int IDX_W     = 4;
    localparam int HASH_W    = 16;
    localparam int HASH_BASE = 2;
    localparam int KEY_W     = 16;
    localparam int CNT_W     = 8;
    localparam int DEPTH     = 2**IDX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              clear_req = 1'b0;
    logic [HASH_W-1:0] in_hash = '0;
    logic [KEY_W-1:0]  in_key = '0;
    logic [CNT_W-1:0]  in_cnt = '0;
    logic              in_ready, out_valid, clear_busy, clear_done;
    logic [KEY_W-1:0]  out_key;
    logic [CNT_W-1:0]  out_cnt;
`ifdef SKETCH_BUCKET_STATS_EN
    logic [31:0]       stat_insert, stat_merge, stat_swap, stat_pass;
`endif

    sketch_bucket_stage #(
        .IDX_W(IDX_W), .HASH_W(HASH_W), .HASH_BASE(HASH_BASE), .KEY_W(KEY_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hash    (in_hash),
        .in_key     (in_key),
        .in_cnt     (in_cnt),
        .out_valid  (out_valid),
        .out_key    (out_key),
        .out_cnt    (out_cnt),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
`ifdef SKETCH_BUCKET_STATS_EN
        , .stat_insert (stat_insert)
        , .stat_merge  (stat_merge)
        , .stat_swap   (stat_swap)
        , .stat_pass   (stat_pass)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [CNT_W-1:0] cnt;
        int               due;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    // Drive one element; when an output is expected it must appear exactly 3 edges after acceptance.
    task automatic applyStimulus(input logic [IDX_W-1:0] idx, input logic [KEY_W-1:0] key,
                                 input logic [CNT_W-1:0] cnt, input bit has_out,
                                 input logic [KEY_W-1:0] okey, input logic [CNT_W-1:0] ocnt);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout got=0 want=1");
            return;
        end
        in_valid = 1'b1;
        in_hash  = HASH_W'($urandom);
        in_hash[HASH_BASE +: IDX_W] = idx;
        in_key   = key;
        in_cnt   = cnt;
        if (has_out) expq.push_back('{key: okey, cnt: ocnt, due: cyc + 4});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic checkDrained(input string name);
        repeat (6) @(negedge clk);
        checkOutput(name, expq.size(), 0);
    endtask

    task automatic doClear(input string name);
        int busy_cycles = 0;
        int dones = 0;
        int ready_bad = 0;
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        repeat (DEPTH + 30) begin
            @(negedge clk);
            if (clear_done) dones++;
            if (clear_busy) begin
                busy_cycles++;
                if (in_ready) ready_bad++;
            end
        end
        checkOutput({name, "_done_pulses"}, dones, 1);
        checkOutput({name, "_ready_low_while_busy"}, ready_bad, 0);
        checkOutput($sformatf("%s_busy_len_%0d_in_range", name, busy_cycles),
                    (busy_cycles >= DEPTH && busy_cycles <= DEPTH + 6) ? 1 : 0, 1);
        checkOutput({name, "_busy_released"}, clear_busy, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (expq.size() > 0 && cyc > expq[0].due) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_out got=none want=key %0h cnt %0d at cycle %0d",
                         expq[0].key, expq[0].cnt, expq[0].due);
                expq.delete(0);
            end
            checks++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_out got=key %0h cnt %0d want=no output", out_key, out_cnt);
                end else begin
                    e = expq.pop_front();
                    if (out_key !== e.key || out_cnt !== e.cnt || cyc != e.due) begin
                        failures++;
                        $display("[TB] FAIL out_element got=key %0h cnt %0d cycle %0d want=key %0h cnt %0d cycle %0d",
                                 out_key, out_cnt, cyc, e.key, e.cnt, e.due);
                    end
                end
            end else if (out_key != '0 || out_cnt != '0) begin
                failures++;
                $display("[TB] FAIL idle_out_nonzero got=key %0h cnt %0d want=0 0", out_key, out_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_key", out_key, 0);
        checkOutput("reset_clear_busy", clear_busy, 0);
        checkOutput("reset_clear_done", clear_done, 0);
        rst_n = 1'b1;

        doClear("init_clear");

        // Insert, merge, zero-count discard, swap, tie pass, then probe the survivor by swapping it out.
        applyStimulus(7, 16'h0005, 3,   0, 0, 0);
        applyStimulus(7, 16'h0005, 4,   0, 0, 0);
        applyStimulus(7, 16'h0055, 0,   0, 0, 0);
        applyStimulus(7, 16'h0009, 8,   1, 16'h0005, 7);
        applyStimulus(7, 16'h0002, 8,   1, 16'h0002, 8);
        applyStimulus(7, 16'h0033, 255, 1, 16'h0009, 8);
        checkDrained("swap_pass_drained");

        // 250 + 10 saturates at 255: a following 255 ties and passes instead of swapping.
        applyStimulus(3, 16'h0005, 250, 0, 0, 0);
        applyStimulus(3, 16'h0005, 10,  0, 0, 0);
        applyStimulus(3, 16'h0006, 255, 1, 16'h0006, 255);
        checkDrained("saturate_drained");

        repeat (4) applyStimulus(9, 16'h0001, 1, 0, 0, 0);
        applyStimulus(9, 16'h0044, 200, 1, 16'h0001, 4);
        checkDrained("fwd_merge_drained");

        applyStimulus(10, 16'h0003, 5,   0, 0, 0);
        applyStimulus(10, 16'h0004, 9,   1, 16'h0003, 5);
        applyStimulus(10, 16'h0005, 2,   1, 16'h0005, 2);
        applyStimulus(10, 16'h0006, 255, 1, 16'h0004, 9);
        checkDrained("fwd_mixed_drained");

        // Two passing elements still in flight when the clear is requested.
        applyStimulus(7,  16'h0066, 1, 1, 16'h0066, 1);
        applyStimulus(10, 16'h0067, 2, 1, 16'h0067, 2);
        doClear("inflight_clear");
        checkOutput("inflight_outputs_seen", expq.size(), 0);
`ifdef SKETCH_BUCKET_STATS_EN
        checkOutput("stat_insert_zeroed", stat_insert, 0);
        checkOutput("stat_merge_zeroed", stat_merge, 0);
        checkOutput("stat_swap_zeroed", stat_swap, 0);
        checkOutput("stat_pass_zeroed", stat_pass, 0);
`endif

        // Every entry must be empty: distinct keys with count 1 would otherwise tie and pass.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(IDX_W'(i), KEY_W'(16'h0100 + i), 1, 0, 0, 0);
        checkDrained("all_empty_drained");

        applyStimulus(0, 16'h0100, 1, 0, 0, 0);
        applyStimulus(0, 16'h0200, 5, 1, 16'h0100, 2);
        applyStimulus(0, 16'h0300, 1, 1, 16'h0300, 1);
        checkDrained("outcomes_drained");
`ifdef SKETCH_BUCKET_STATS_EN
        checkOutput("stat_insert", stat_insert, DEPTH);
        checkOutput("stat_merge", stat_merge, 1);
        checkOutput("stat_swap", stat_swap, 1);
        checkOutput("stat_pass", stat_pass, 1);
`endif

        // Reset in the middle of the sweep abandons it with no completion pulse.
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("busy_before_abort", clear_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", clear_busy, 0);
        checkOutput("abort_done", clear_done, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_out_valid", out_valid, 0);
`ifdef SKETCH_BUCKET_STATS_EN
        checkOutput("abort_stat_insert", stat_insert, 0);
        checkOutput("abort_stat_pass", stat_pass, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (DEPTH + 20) begin
            @(negedge clk);
            if (clear_done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        checkOutput("abort_idle_busy", clear_busy, 0);
        checkOutput("abort_idle_ready", in_ready, 1);
        checkOutput("final_queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sketch_bucket_stage.md
SKETCH_BUCKET_STAGE -- requirements
Module: sketch_bucket_stage

Interface
REQ-001 SHALL have parameter IDX_W, default 10, meaning bucket index width; DEPTH = 2**IDX_W entries.
REQ-002 SHALL have parameter HASH_W, default 32, meaning width of in_hash.
REQ-003 SHALL have parameter HASH_BASE, default 0, meaning the LSB of the index slice in_hash[HASH_BASE+IDX_W-1:HASH_BASE].
REQ-004 SHALL have parameters KEY_W and CNT_W, default 32 each, meaning the key (ID) and count widths; entry width is KEY_W+CNT_W.
REQ-005 SHALL have port clk, input, 1, the single clock; the block has one clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-008 SHALL have ports in_hash (input, HASH_W), in_key (input, KEY_W) and in_cnt (input, CNT_W), the incoming element.
REQ-009 SHALL have ports out_valid (output, 1), out_key (output, KEY_W) and out_cnt (output, CNT_W), the evicted or passed element for the next stage; there is no backpressure.
REQ-010 SHALL have ports clear_req (input, 1), clear_busy (output, 1) and clear_done (output, 1), the table-clear control.

Function
REQ-011 SHALL accept an element on a clk edge with in_valid && in_ready; an element with in_cnt==0 is accepted and discarded (no RAM write, no output).
REQ-012 SHALL treat an entry equal to all zeros as empty.
REQ-013 SHALL apply the following at the decide stage:
- empty: write {in_key,in_cnt}; no output.
- key match: write {key, sat(stored+in_cnt)}; no output.
- in_cnt > stored cnt: write the incoming element; output the stored element.
- otherwise (including equal counts): no write; output the incoming element.
REQ-014 SHALL saturate the merged count at 2**CNT_W-1 and never wrap.
REQ-015 SHALL be a fixed pipeline: element accepted at cycle t produces out_valid at t+3; the RAM write is visible to reads from t+4; throughput is one element per cycle.
REQ-016 SHALL forward in-flight writes: the decide stage uses the most recent value of its index, including writes by the immediately preceding accepted elements (back-to-back same index gives identical results to widely spaced input).
REQ-017 SHALL hold out_key and out_cnt at zero whenever out_valid is 0.
REQ-018 SHALL implement clear with FSM IDLE -> DRAIN -> CLEAR -> IDLE:
- IDLE: in_ready=1; clear_req moves to DRAIN.
- DRAIN: in_ready=0; stays until the pipeline is empty.
- CLEAR: writes zero to addresses 0..DEPTH-1, one per cycle.
- After writing DEPTH-1: returns to IDLE and pulses clear_done for 1 cycle.
REQ-019 SHALL assert clear_busy in DRAIN and CLEAR; clear_req outside IDLE is ignored.
REQ-020 SHALL have the RAM contents undefined after power-up; software issues clear before use.

Reset
REQ-021 SHALL, while rst_n=0, force FSM=IDLE, all pipeline valids=0, out_valid=0, out_key=out_cnt=0, clear_busy=clear_done=0, and in_ready=0 while reset is asserted.
REQ-022 SHALL, on reset asserted mid-clear or mid-pipeline, abandon in-flight elements and the clear sweep without a completion pulse; RAM contents are then undefined.

Configuration
REQ-023 SHALL, when macro SKETCH_BUCKET_STATS_EN is defined, add parameter STAT_W (default 32) and outputs stat_insert, stat_merge, stat_swap and stat_pass (STAT_W each).
- Each counter increments once per decide-stage outcome of its kind.
- Counters saturate, reset to 0, and zero at clear_done.
REQ-024 SHALL, without SKETCH_BUCKET_STATS_EN, have none of those ports or counters; all other behaviour is identical.

Structure
REQ-025 SHALL place the entry struct typedef, the outcome enum (INSERT/MERGE/SWAP/PASS) and the clear FSM state enum in the shared package sketch_pkg.
REQ-026 SHALL instantiate one sub-module sdp_ram: simple dual-port, parameterised depth and width, one write port, one read port with 1-cycle registered read latency, inferable.

Verification
REQ-027 SHALL cover: after clear, input key=5 cnt=3 idx=7 -> no output; then key=5 cnt=4 idx=7 -> entry {5,7}, no output.
REQ-028 SHALL cover: entry {5,7} at idx 7, input key=9 cnt=8 -> out {5,7} at t+3; entry {9,8}. Then key=2 cnt=8 -> out {2,8} (tie passes).
REQ-029 SHALL cover: CNT_W=8 with entry {5,250}, input key=5 cnt=10 -> entry {5,255}.
REQ-030 SHALL cover: 4 back-to-back same-index inputs key=1 cnt=1 -> entry {1,4}, no outputs (forwarding).
REQ-031 SHALL cover: clear_req with 2 elements in flight -> both complete, in_ready low, DEPTH write cycles, single clear_done pulse, then all entries read empty.
REQ-032 SHALL cover: rst_n pulsed mid-CLEAR -> clear_busy=0, no clear_done, FSM=IDLE; with SKETCH_BUCKET_STATS_EN, 1 insert + 1 merge + 1 swap + 1 pass -> each counter=1.
